// File: rtl/uart_conf_parser.sv
// rtl/uart_conf_parser.sv - 8N1 UART receiver with comma-separated decimal field parser
module uart_conf_parser #(
    parameter int CLK_DIV = 16,
    parameter int N_PAR   = 5,
    parameter int PAR_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     uart_data,
    output logic [N_PAR*PAR_W-1:0]   conf,
    output logic                     conf_valid,
    output logic [7:0]               rx_byte,
    output logic                     rx_valid,
    output logic                     frame_err,
    output logic                     parse_err
);

    localparam int DW = $clog2(CLK_DIV);
    localparam int IW = (N_PAR > 1) ? $clog2(N_PAR) : 1;
    localparam logic [PAR_W-1:0] MAXV = '1;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic {P_FIELD, P_DISCARD} p_state_t;

    logic [1:0]      sync_q;
    logic            rxd;
    rx_state_t       rx_state, rx_next;
    logic [DW-1:0]   div;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift;
    logic            half_tick, bit_tick;

    p_state_t        p_state, p_next;
    logic [PAR_W-1:0] acc, acc_n;
    logic            seen, seen_n;
    logic [IW-1:0]   idx, idx_n;
    logic [PAR_W-1:0] shadow [N_PAR];
    logic            shadow_we, commit, perr;
    logic [PAR_W+3:0] prod;
    logic            is_digit;

    assign rxd       = sync_q[1];
    assign half_tick = (div == DW'(CLK_DIV/2 - 1));
    assign bit_tick  = (div == DW'(CLK_DIV - 1));

    // Two-flop synchroniser for the asynchronous RX line; idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], uart_data};
    end

    // RX state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state <= RX_IDLE;
        else        rx_state <= rx_next;
    end

    // RX next state: start bit is re-checked mid-bit so short low glitches fall back to idle.
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (!rxd) rx_next = RX_START;
            RX_START: if (half_tick) rx_next = rxd ? RX_IDLE : RX_DATA;
            RX_DATA:  if (bit_tick && bit_cnt == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (bit_tick) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    // RX datapath: divider, bit counter, shift register and the byte/error strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div       <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            rx_byte   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (rx_state)
                RX_IDLE: div <= '0;
                RX_START: begin
                    div     <= half_tick ? '0 : div + 1'b1;
                    bit_cnt <= '0;
                end
                RX_DATA: begin
                    div <= bit_tick ? '0 : div + 1'b1;
                    if (bit_tick) begin
                        shift   <= {rxd, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    div <= bit_tick ? '0 : div + 1'b1;
                    if (bit_tick) begin
                        if (rxd) begin
                            rx_byte  <= shift;
                            rx_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end
                default: div <= '0;
            endcase
        end
    end

    // Saturating decimal accumulate; four guard bits keep acc*10+9 from wrapping.
    always_comb begin
        prod     = ({4'b0000, acc} << 3) + ({4'b0000, acc} << 1) + {{PAR_W{1'b0}}, rx_byte[3:0]};
        is_digit = (rx_byte >= 8'h30) && (rx_byte <= 8'h39);
    end

    // Parser next state and working-register updates, evaluated on each received byte.
    always_comb begin
        p_next    = p_state;
        acc_n     = acc;
        seen_n    = seen;
        idx_n     = idx;
        shadow_we = 1'b0;
        commit    = 1'b0;
        perr      = 1'b0;
        if (frame_err) begin
            p_next = P_DISCARD;
        end else if (rx_valid) begin
            if (p_state == P_FIELD) begin
                if (is_digit) begin
                    acc_n  = (prod > {4'b0000, MAXV}) ? MAXV : prod[PAR_W-1:0];
                    seen_n = 1'b1;
                end else if (rx_byte == 8'h2C) begin
                    if (seen && idx < IW'(N_PAR - 1)) begin
                        shadow_we = 1'b1;
                        idx_n     = idx + 1'b1;
                        acc_n     = '0;
                        seen_n    = 1'b0;
                    end else begin
                        perr   = 1'b1;
                        p_next = P_DISCARD;
                    end
                end else if (rx_byte == 8'h0A) begin
                    if (seen && idx == IW'(N_PAR - 1)) commit = 1'b1;
                    else                               perr   = 1'b1;
                    idx_n  = '0;
                    acc_n  = '0;
                    seen_n = 1'b0;
                end else if (rx_byte != 8'h0D && rx_byte != 8'h20) begin
                    perr   = 1'b1;
                    p_next = P_DISCARD;
                end
            end else if (rx_byte == 8'h0A) begin
                p_next = P_FIELD;
                idx_n  = '0;
                acc_n  = '0;
                seen_n = 1'b0;
            end
        end
    end

    // Parser registers; conf is only written as a whole on a clean line end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_state    <= P_FIELD;
            acc        <= '0;
            seen       <= 1'b0;
            idx        <= '0;
            conf       <= '0;
            conf_valid <= 1'b0;
            parse_err  <= 1'b0;
            for (int k = 0; k < N_PAR; k++) shadow[k] <= '0;
        end else begin
            p_state    <= p_next;
            acc        <= acc_n;
            seen       <= seen_n;
            idx        <= idx_n;
            conf_valid <= commit;
            parse_err  <= perr;
            if (shadow_we) shadow[idx] <= acc;
            if (commit) begin
                for (int k = 0; k < N_PAR - 1; k++) conf[k*PAR_W +: PAR_W] <= shadow[k];
                conf[(N_PAR-1)*PAR_W +: PAR_W] <= acc;
            end
        end
    end

endmodule

// File: tb/tb_uart_conf_parser.sv
// tb/tb_uart_conf_parser.sv - self-checking bench for uart_conf_parser
module tb_uart_conf_parser;

    localparam int CLK_DIV = 8;
    localparam int N_PAR   = 3;
    localparam int PAR_W   = 16;
    localparam int CW      = N_PAR * PAR_W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          uart_data = 1'b1;
    logic [CW-1:0] conf;
    logic          conf_valid;
    logic [7:0]    rx_byte;
    logic          rx_valid, frame_err, parse_err;

    uart_conf_parser #(.CLK_DIV(CLK_DIV), .N_PAR(N_PAR), .PAR_W(PAR_W)) dut (
        .clk(clk), .rst_n(rst_n), .uart_data(uart_data),
        .conf(conf), .conf_valid(conf_valid), .rx_byte(rx_byte),
        .rx_valid(rx_valid), .frame_err(frame_err), .parse_err(parse_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         line;
        bit            commit;
        logic [CW-1:0] exp_conf;
        int            perr;
        int            bad;
    } vec_t;

    vec_t          tab [7];
    logic [CW-1:0] sb [$];
    logic [CW-1:0] cur_conf;
    int            errs = 0, checks = 0;
    int            n_rxv, n_ferr, n_perr, n_cv;

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Output monitor: counts strobes and pops the scoreboard on each commit.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid)  n_rxv++;
            if (frame_err) n_ferr++;
            if (parse_err) n_perr++;
            if (conf_valid) begin
                n_cv++;
                if (sb.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL unexpected_commit: got conf %0h expected none", conf);
                end else begin
                    check("commit_conf", conf, sb.pop_front());
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit good_stop);
        uart_data = 1'b0;
        repeat (CLK_DIV) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_data = b[i];
            repeat (CLK_DIV) @(posedge clk);
        end
        uart_data = good_stop;
        repeat (CLK_DIV) @(posedge clk);
        uart_data = 1'b1;
    endtask

    task automatic clr_counts();
        n_rxv = 0; n_ferr = 0; n_perr = 0; n_cv = 0;
    endtask

    task automatic run_vec(input vec_t v);
        int exp_rxv;
        clr_counts();
        if (v.commit) sb.push_back(v.exp_conf);
        for (int i = 0; i < v.line.len(); i++) send_byte(v.line[i], i != v.bad);
        repeat (20) @(posedge clk);
        @(negedge clk);
        if (v.commit) cur_conf = v.exp_conf;
        exp_rxv = v.line.len() - ((v.bad >= 0) ? 1 : 0);
        check({"rx_valid_count ", v.line}, CW'(n_rxv), CW'(exp_rxv));
        check("parse_err_count", CW'(n_perr), CW'(v.perr));
        check("frame_err_count", CW'(n_ferr), CW'((v.bad >= 0) ? 1 : 0));
        check("conf_valid_cycles", CW'(n_cv), CW'(v.commit));
        check("conf_held", conf, cur_conf);
        check("commit_missing", CW'(sb.size()), '0);
        sb.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tab[0] = '{"72,424,45\n", 1'b1, {16'd45, 16'd424, 16'd72}, 0, -1};
        tab[1] = '{"7a,1,2\n",    1'b0, '0, 1, -1};
        tab[2] = '{"1,2\n",       1'b0, '0, 1, -1};
        tab[3] = '{"9,8,7\n",     1'b1, {16'd7, 16'd8, 16'd9}, 0, -1};
        tab[4] = '{"70000,1,2\n", 1'b1, {16'd2, 16'd1, 16'd65535}, 0, -1};
        tab[5] = '{"5,4,3\n",     1'b0, '0, 0, 2};
        tab[6] = '{"1,1,1\n",     1'b1, {16'd1, 16'd1, 16'd1}, 0, -1};
        cur_conf = '0;
        clr_counts();

        repeat (3) @(posedge clk);
        #1;
        check("reset_conf", conf, '0);
        check("reset_strobes", CW'({conf_valid, rx_valid, frame_err, parse_err}), '0);
        check("reset_rx_byte", CW'(rx_byte), '0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        for (int i = 0; i < 7; i++) run_vec(tab[i]);

        // Short low glitches on an idle line, then a real byte.
        clr_counts();
        uart_data = 1'b0;
        repeat (2) @(posedge clk);
        uart_data = 1'b1;
        repeat (20) @(posedge clk);
        uart_data = 1'b0;
        repeat (3) @(posedge clk);
        uart_data = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("glitch_rx_valid", CW'(n_rxv), '0);
        check("glitch_errors", CW'(n_ferr + n_perr), '0);
        send_byte(8'h20, 1'b1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("post_glitch_rx_valid", CW'(n_rxv), CW'(1));
        check("post_glitch_rx_byte", CW'(rx_byte), CW'(8'h20));
        check("post_glitch_errors", CW'(n_ferr + n_perr), '0);

        // Reset in the middle of the third byte of "3,3,3\n".
        clr_counts();
        send_byte("3", 1'b1);
        send_byte(",", 1'b1);
        uart_data = 1'b0;
        repeat (CLK_DIV) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            uart_data = ((8'h33 >> i) & 8'h01) != 0;
            repeat (CLK_DIV) @(posedge clk);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_conf", conf, '0);
        check("midreset_strobes", CW'({conf_valid, rx_valid, frame_err, parse_err}), '0);
        check("midreset_rx_byte", CW'(rx_byte), '0);
        check("midreset_no_commit", CW'(n_cv), '0);
        uart_data = 1'b1;
        cur_conf = '0;
        repeat (5) @(posedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        run_vec('{"4,5,6\n", 1'b1, {16'd6, 16'd5, 16'd4}, 0, -1});

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
